pc_seq_unit: RTL and testbench

//   Parametrised program-counter unit for the MIPS core; replaces the fixed 32-bit PC register.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_redirect_buf.sv | 31 +++
 rtl/pc_seq_unit.sv | 60 ++++++
 tb/tb_pc_seq_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, state encoding and target alignment helper for the PC unit
package pc_pkg;
  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] PC_EXC_VEC = 32'h0040_0004;
  localparam int PC_STEP = 4;
  typedef enum logic {RUN = 1'b0, PEND = 1'b1} pc_state_t;
  typedef struct packed {
    logic [63:0] addr;
    logic mis;
  } align_t;
  function automatic align_t align_addr(input logic [63:0] addr, input int unsigned align);
    logic [63:0] m;
    m = (64'd1 << align) - 64'd1;
    align_addr.addr = addr & ~m;
    align_addr.mis = |(addr & m);
  endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry redirect buffer; capture stores a target, consume clears it.
//   CLK, RST_n (async, active-high) | capture, capture_addr, consume -> valid, addr
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_addr,
  input  logic             consume,
  output logic             valid,
  output logic [WIDTH-1:0] addr
);
  pc_state_t state, state_nxt;
  logic [WIDTH-1:0] pend_addr;
  always_ff @(negedge CLK or posedge RST_n)
    if (RST_n) begin
      state <= RUN;
      pend_addr <= '0;
    end else begin
      state <= state_nxt;
      if (capture && !consume) pend_addr <= capture_addr;
    end
  always_comb state_nxt = consume ? RUN : capture ? PEND : state;
  always_comb begin
    valid = (state == PEND);
    addr = pend_addr;
  end
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter with sequential step, redirects, exception entry/ERET, stall buffer.
//   CLK (negedge), RST_n (async, active-high), ena, redirect_valid/addr, exc_req, eret_req
//   -> pc_out, pc_seq, epc_out, pending_out, misalign
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [31:0] EXC_VEC = PC_EXC_VEC,
  parameter int STEP = PC_STEP
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ena,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             exc_req,
  input  logic             eret_req,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic [WIDTH-1:0] epc_out,
  output logic             pending_out,
  output logic             misalign
);
  localparam int ALIGN = $clog2(STEP);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
  logic [WIDTH-1:0] pc, epc, tgt, buf_addr, pc_nxt;
  logic buf_valid, use_tgt;
  align_t al;
  assign al = align_addr(64'(redirect_addr), ALIGN);
  assign tgt = al.addr[WIDTH-1:0];
  // a target is only consumed when it is buffered (stall) or actually wins the priority mux
  assign use_tgt = redirect_valid & (~ena | ~(exc_req | eret_req));
  pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
    .CLK(CLK),
    .RST_n(RST_n),
    .capture(~ena & redirect_valid),
    .capture_addr(tgt),
    .consume(ena),
    .valid(buf_valid),
    .addr(buf_addr)
  );
  always_comb
    pc_nxt = exc_req ? EXC_PC : eret_req ? epc : redirect_valid ? tgt : buf_valid ? buf_addr : pc_seq;
  always_ff @(negedge CLK or posedge RST_n)
    if (RST_n) begin
      pc <= RST_PC;
      epc <= '0;
      misalign <= 1'b0;
    end else begin
      if (ena) pc <= pc_nxt;
      if (ena && exc_req) epc <= pc;
      if (use_tgt && al.mis) misalign <= 1'b1;
    end
  assign pc_seq = pc + WIDTH'(STEP);
  assign pc_out = pc;
  assign epc_out = epc;
  assign pending_out = buf_valid;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed vector table plus hand-written reset/wrap sequences for pc_seq_unit
module tb_pc_seq_unit;
  logic CLK = 0, RST_n = 1;
  logic ena = 0, rv = 0, exc = 0, eret = 0;
  logic [31:0] ra = '0;
  logic [31:0] pc_out, pc_seq, epc_out;
  logic pend, mis;
  logic ena8 = 0;
  logic [7:0] pc8, seq8, epc8;
  logic pend8, mis8;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  pc_seq_unit dut (
    .CLK(CLK), .RST_n(RST_n), .ena(ena), .redirect_valid(rv), .redirect_addr(ra),
    .exc_req(exc), .eret_req(eret), .pc_out(pc_out), .pc_seq(pc_seq), .epc_out(epc_out),
    .pending_out(pend), .misalign(mis)
  );

  pc_seq_unit #(.WIDTH(8), .RESET_VEC(32'h0000_00FC), .STEP(4)) dut8 (
    .CLK(CLK), .RST_n(RST_n), .ena(ena8), .redirect_valid(1'b0), .redirect_addr(8'h00),
    .exc_req(1'b0), .eret_req(1'b0), .pc_out(pc8), .pc_seq(seq8), .epc_out(epc8),
    .pending_out(pend8), .misalign(mis8)
  );

  typedef struct {
    logic e, v;
    logic [31:0] a;
    logic x, r;
    logic [31:0] pc, epc;
    logic pd, ms;
  } vec_t;
  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic [31:0] a, input logic x, input logic r);
    ena = e; rv = v; ra = a; exc = x; eret = r;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 32'h0, 0, 0, 32'h0040_0004, 32'h0, 0, 0};
    vecs[1]  = '{1, 0, 32'h0, 0, 0, 32'h0040_0008, 32'h0, 0, 0};
    vecs[2]  = '{1, 0, 32'h0, 0, 0, 32'h0040_000C, 32'h0, 0, 0};
    vecs[3]  = '{0, 1, 32'h0040_0100, 0, 0, 32'h0040_000C, 32'h0, 1, 0};
    vecs[4]  = '{0, 1, 32'h0040_0200, 0, 0, 32'h0040_000C, 32'h0, 1, 0};
    vecs[5]  = '{1, 0, 32'h0, 0, 0, 32'h0040_0200, 32'h0, 0, 0};
    vecs[6]  = '{1, 0, 32'h0, 0, 0, 32'h0040_0204, 32'h0, 0, 0};
    vecs[7]  = '{1, 1, 32'h0040_0020, 0, 0, 32'h0040_0020, 32'h0, 0, 0};
    vecs[8]  = '{1, 1, 32'h0040_0500, 1, 0, 32'h0040_0004, 32'h0040_0020, 0, 0};
    vecs[9]  = '{1, 0, 32'h0, 0, 1, 32'h0040_0020, 32'h0040_0020, 0, 0};
    vecs[10] = '{1, 0, 32'h0, 0, 0, 32'h0040_0024, 32'h0040_0020, 0, 0};
    vecs[11] = '{0, 1, 32'h0040_0300, 0, 0, 32'h0040_0024, 32'h0040_0020, 1, 0};
    vecs[12] = '{1, 0, 32'h0, 1, 0, 32'h0040_0004, 32'h0040_0024, 0, 0};
    vecs[13] = '{1, 0, 32'h0, 0, 0, 32'h0040_0008, 32'h0040_0024, 0, 0};
    vecs[14] = '{0, 0, 32'h0, 1, 0, 32'h0040_0008, 32'h0040_0024, 0, 0};
    vecs[15] = '{1, 1, 32'h0040_0103, 0, 0, 32'h0040_0100, 32'h0040_0024, 0, 1};
    vecs[16] = '{1, 1, 32'h0040_0200, 0, 0, 32'h0040_0200, 32'h0040_0024, 0, 1};
    vecs[17] = '{0, 1, 32'h0040_0401, 0, 0, 32'h0040_0200, 32'h0040_0024, 1, 1};
    vecs[18] = '{1, 0, 32'h0, 0, 0, 32'h0040_0400, 32'h0040_0024, 0, 1};
    vecs[19] = '{1, 0, 32'h0, 1, 1, 32'h0040_0004, 32'h0040_0400, 0, 1};
    vecs[20] = '{0, 1, 32'h0040_0600, 0, 0, 32'h0040_0004, 32'h0040_0400, 1, 1};
    vecs[21] = '{1, 1, 32'h0040_0700, 0, 0, 32'h0040_0700, 32'h0040_0400, 0, 1};
    vecs[22] = '{1, 0, 32'h0, 0, 0, 32'h0040_0704, 32'h0040_0400, 0, 1};
    #12;
    chk("reset_pc", pc_out, 32'h0040_0000);
    chk("reset_seq", pc_seq, 32'h0040_0004);
    chk("reset_epc", epc_out, 32'h0);
    chk("reset_pend", {31'b0, pend}, 32'h0);
    chk("reset_mis", {31'b0, mis}, 32'h0);
    chk("reset_pc8", {24'b0, pc8}, 32'hFC);
    chk("reset_seq8", {24'b0, seq8}, 32'h00);
    @(posedge CLK);
    RST_n = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].e, vecs[i].v, vecs[i].a, vecs[i].x, vecs[i].r);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_epc", i), epc_out, vecs[i].epc);
      chk($sformatf("v%0d_pend", i), {31'b0, pend}, {31'b0, vecs[i].pd});
      chk($sformatf("v%0d_mis", i), {31'b0, mis}, {31'b0, vecs[i].ms});
    end
    drive(1, 1, 32'h0040_0010, 0, 0);
    drive(0, 1, 32'h0040_0900, 0, 0);
    chk("pre_rst_pend", {31'b0, pend}, 32'h1);
    #2 RST_n = 1;
    #1;
    chk("async_rst_pc", pc_out, 32'h0040_0000);
    chk("async_rst_pend", {31'b0, pend}, 32'h0);
    chk("async_rst_epc", epc_out, 32'h0);
    chk("async_rst_mis", {31'b0, mis}, 32'h0);
    #1 RST_n = 0;
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 32'h0, 0, 0);
      chk($sformatf("post_rst_%0d", k), pc_out, 32'h0040_0000 + 32'(4 * k));
    end
    chk("post_rst_pend", {31'b0, pend}, 32'h0);
    drive(0, 1, 32'h0040_0802, 0, 0);
    chk("stall_mis", {31'b0, mis}, 32'h1);
    chk("stall_pend", {31'b0, pend}, 32'h1);
    drive(1, 0, 32'h0, 0, 0);
    chk("stall_aligned_pc", pc_out, 32'h0040_0800);
    ena = 0; rv = 0;
    ena8 = 1;
    @(negedge CLK);
    #1;
    ena8 = 0;
    chk("wrap_pc8", {24'b0, pc8}, 32'h00);
    chk("wrap_seq8", {24'b0, seq8}, 32'h04);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
